// File: rtl/nbit_accumulator_pkg.sv
// Shared definitions for the multi-operand accumulator stage:
// state encoding, default widths and the signed-overflow helper.
package nbit_accumulator_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Two's-complement overflow: both addends share a sign and the sum's sign differs.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/nbit_accumulator_if.sv
// Job, operand and result handshake bundle of the accumulator stage.
// slave = the accumulator itself, master = the producer/consumer side.
interface nbit_accumulator_if #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) ();

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_count
  );

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_count
  );

endinterface

// File: rtl/nbit_accumulator_rca_core.sv
// Parameterised combinational ripple-carry adder: one full adder per bit,
// carry rippling from bit 0 upward.
module rca_core #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic carry_s;

  // Full-adder chain; the carry is a blocking temporary so no feedback net forms.
  always_comb begin
    carry_s = Cin;
    S       = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      S[i]    = A[i] ^ B[i] ^ carry_s;
      carry_s = (A[i] & B[i]) | (carry_s & (A[i] ^ B[i]));
    end
    Cout = carry_s;
  end

endmodule

// File: rtl/nbit_accumulator.sv
// Multi-operand summing stage: the running sum is fed back into the ripple
// core's A input, one operand per accepted beat, and the final sum with
// sticky carry/overflow flags is presented on the result handshake.
module nbit_accumulator
  import nbit_accumulator_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  nbit_accumulator_if.slave bus
);

  state_e           state_r, state_s;
  logic [N-1:0]     acc_r;
  logic [N-1:0]     sum_s;
  logic [CNT_W-1:0] cnt_r, len_r, cnt_inc_s;
  logic             cout_r, ovf_r, core_cout_s;
  logic             beat_s, last_beat_s;
  logic             in_ready_r, out_valid_r;

  rca_core #(.N(N)) u_core (
    .A   (acc_r),
    .B   (bus.in_data),
    .Cin (1'b0),
    .S   (sum_s),
    .Cout(core_cout_s)
  );

  assign cnt_inc_s   = cnt_r + CNT_W'(1);
  assign beat_s      = (state_r == ST_ACCUM) && bus.in_valid;
  assign last_beat_s = beat_s && (cnt_inc_s == len_r);

  // Next-state decode; start and len only matter in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len == {CNT_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_beat_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state,
  // so in_ready/out_valid depend on state only and are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_ACCUM);
      out_valid_r <= (state_s == ST_DONE);
    end
  end

  // Accumulator, operand counter, sticky flags and latched job length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {N{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      len_r  <= {CNT_W{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      acc_r  <= {N{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      len_r  <= bus.len;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (beat_s) begin
      acc_r  <= sum_s;
      cnt_r  <= cnt_inc_s;
      cout_r <= cout_r | core_cout_s;
      ovf_r  <= ovf_r | add_ovf(acc_r[N-1], bus.in_data[N-1], sum_s[N-1]);
    end else begin
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
      len_r  <= len_r;
      cout_r <= cout_r;
      ovf_r  <= ovf_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = acc_r;
  assign bus.out_cout  = cout_r;
  assign bus.out_ovf   = ovf_r;
  assign bus.out_count = cnt_r;

endmodule

// File: tb/tb_nbit_accumulator.sv
// Directed, table-driven bench for nbit_accumulator plus hand-written
// reset-mid-job and ignored-start sequences.
module tb_nbit_accumulator;

  localparam int N     = 32;
  localparam int CNT_W = 8;

  typedef struct {
    logic [CNT_W-1:0]  len;
    logic [3:0][N-1:0] ops;
    logic [N-1:0]      sum;
    logic              cout;
    logic              ovf;
    int                hold;   // cycles out_ready stays low in DONE
    bit                gaps;   // random in_valid bubbles
    bit                poke;   // start pulse during ACCUM after the first beat
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs [6];

  nbit_accumulator_if #(.N(N), .CNT_W(CNT_W)) bus ();

  nbit_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_sum"},   bus.out_sum,            32'd0);
    check({tag, "_out_cout"},  {31'd0, bus.out_cout},  32'd0);
    check({tag, "_out_ovf"},   {31'd0, bus.out_ovf},   32'd0);
    check({tag, "_out_count"}, {24'd0, bus.out_count}, 32'd0);
  endtask

  task automatic run_job(input vec_t v);
    int n;
    bus.start = 1'b1;
    bus.len   = v.len;
    step();
    bus.start = 1'b0;
    bus.len   = 8'd0;
    if (v.len == 8'd0) begin
      check("empty_valid_next", {31'd0, bus.out_valid}, 32'd1);
    end else begin
      check("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
      for (int i = 0; i < int'(v.len); i++) begin
        if (v.gaps) begin
          n = int'($urandom_range(0, 2));
          for (int g = 0; g < n; g++) begin
            bus.in_valid = 1'b0;
            step();
            check("stall_count", {24'd0, bus.out_count}, i);
            check("stall_ready", {31'd0, bus.in_ready}, 32'd1);
          end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v.ops[i];
        step();
        bus.in_valid = 1'b0;
        if (v.poke && i == 0) begin
          bus.start = 1'b1;
          bus.len   = 8'd1;
          step();
          bus.start = 1'b0;
          bus.len   = 8'd0;
          check("ign_start_count", {24'd0, bus.out_count}, 32'd1);
          check("ign_start_ready", {31'd0, bus.in_ready}, 32'd1);
          check("ign_start_valid", {31'd0, bus.out_valid}, 32'd0);
        end
      end
    end
    check("done_valid",  {31'd0, bus.out_valid}, 32'd1);
    check("done_ready",  {31'd0, bus.in_ready},  32'd0);
    check("done_sum",    bus.out_sum,            v.sum);
    check("done_cout",   {31'd0, bus.out_cout},  {31'd0, v.cout});
    check("done_ovf",    {31'd0, bus.out_ovf},   {31'd0, v.ovf});
    check("done_count",  {24'd0, bus.out_count}, {24'd0, v.len});
    for (int h = 0; h < v.hold; h++) begin
      step();
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_sum",   bus.out_sum,            v.sum);
      check("hold_flags", {30'd0, bus.out_cout, bus.out_ovf}, {30'd0, v.cout, v.ovf});
      check("hold_count", {24'd0, bus.out_count}, {24'd0, v.len});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    check("idle_ready", {31'd0, bus.in_ready},  32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b0;

    //            len    ops (index 3..0)                                            sum            cout  ovf   hold gaps poke
    vecs[0] = '{8'd2, {32'd0, 32'd0, 32'd4565, 32'd1209},                            32'd5774,      1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[1] = '{8'd3, {32'd0, 32'd5, 32'd1, 32'hFFFF_FFFF},                          32'd5,         1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[2] = '{8'd2, {32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF},                          32'h8000_0000, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[3] = '{8'd0, {32'd0, 32'd0, 32'd0, 32'd0},                                  32'd0,         1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[4] = '{8'd4, {32'd4, 32'd3, 32'h8000_0000, 32'h8000_0000},                  32'd7,         1'b1, 1'b1, 5, 1'b1, 1'b0};
    vecs[5] = '{8'd3, {32'd0, 32'd300, 32'd200, 32'd100},                            32'd600,       1'b0, 1'b0, 0, 1'b0, 1'b1};

    // Reset state
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // Reset mid-job: two beats into a four-operand job
    bus.start = 1'b1;
    bus.len   = 8'd4;
    step();
    bus.start = 1'b0;
    bus.len   = 8'd0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd10;
    step();
    bus.in_data  = 32'd20;
    step();
    bus.in_valid = 1'b0;
    check("midjob_sum", bus.out_sum, 32'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #3;
    rst_n = 1'b1;
    step();
    check("rst_release_ready", {31'd0, bus.in_ready},  32'd0);
    check("rst_release_valid", {31'd0, bus.out_valid}, 32'd0);

    // Table-driven jobs, back to back
    for (int k = 0; k < 6; k++) begin
      run_job(vecs[k]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nbit_accumulator.md
# nbit_accumulator

Sequential stage wrapped around an N-bit ripple-carry adder core. It consumes a stream of N-bit operands over a valid/ready handshake and feeds the registered running sum back into the adder's A input. After a programmed number of operands, it presents the final sum with sticky carry-out and signed-overflow flags on an output handshake. It sits directly downstream of operand producers and upstream of any result consumer, turning the combinational adder into a multi-operand summing stage.

## Interface
- N, 32, operand/sum width
- CNT_W, 8, width of operand-count field (max 2^CNT_W−1 operands per job)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job start pulse, accepted only in IDLE
- len  in  CNT_W  number of operands in the job, sampled with start
- in_valid  in  1  operand valid
- in_ready  out  1  stage accepting operands
- in_data  in  N  operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  N  final sum, modulo 2^N
- out_cout  out  1  sticky: any addition in the job produced carry-out
- out_ovf  out  1  sticky: any addition in the job overflowed (two's complement)
- out_count  out  CNT_W  operands actually summed (equals len)

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: acc←0, cnt←0, cout/ovf flags←0, len latched.
  - If len==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On each in_valid&&in_ready beat: acc←S of core(A=acc, B=in_data, Cin=0); cnt←cnt+1; cout_flag |= core Cout; ovf_flag |= (acc[N-1]==in_data[N-1]) && (S[N-1]!=acc[N-1]).
  - When a beat makes cnt+1==len_latched, go to DONE on the same edge.
- DONE:
  - out_valid=1; out_sum/out_cout/out_ovf/out_count driven directly from registers and held stable.
  - in_ready=0.
  - On out_ready, go to IDLE.
- start is ignored in ACCUM and DONE, and len is not resampled.
- Sum wraps modulo 2^N; the wrap is recorded only in out_cout.
- Reset (at any time, including mid-job): state=IDLE; acc, cnt, flags and len_latched cleared. All outputs are 0 at reset: in_ready=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_count=0.

## Timing
- start in IDLE at edge k:
  - ACCUM visible after edge k, so in_ready=1 from cycle k+1.
  - With len==0, out_valid=1 from cycle k+1.
- Throughput in ACCUM is one operand per cycle; in_valid gaps stall with no state change.
- Latency: the final beat accepted at edge m gives out_valid=1 and the final out_sum in cycle m+1.
- The combinational path from acc through the ripple core to acc is N full-adder stages long; no pipelining inside the stage.
- Back-to-back jobs:
  - Handshake at edge j returns the stage to IDLE.
  - The earliest next start is sampled at edge j+1.
  - Minimum job overhead is 2 cycles plus len.
- in_ready and out_valid are never both 1.
- in_ready is a pure function of state; it does not depend on in_valid.

## Structure
- Shared package holds the state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the defaults N=32 and CNT_W=8.
- One sub-module, rca_core:
  - Parameterised N-bit combinational ripple-carry adder with ports A, B, Cin, S, Cout.
  - Instantiated once, with Cin tied to 0.
- The top level holds the FSM, counter, accumulator and flag registers.

## Test plan
- Reset mid-job:
  - Stimulus: rst_n low during ACCUM after 2 beats.
  - Required: all outputs 0 immediately (asynchronous); after release, state is IDLE and in_ready=0.
- Two-operand job:
  - Stimulus: len=2, operands 1209 then 4565, out_ready=1.
  - Required: out_sum=5774, out_cout=0, out_ovf=0, out_count=2; out_valid is asserted exactly one cycle after the second beat and held for one cycle.
- Unsigned wrap:
  - Stimulus: len=3, operands 32'hFFFF_FFFF, 1, 5.
  - Required: out_sum=5, out_cout=1, out_ovf=0.
- Signed overflow:
  - Stimulus: len=2, operands 32'h7FFF_FFFF, 1.
  - Required: out_sum=32'h8000_0000, out_ovf=1, out_cout=0.
- Empty job and ignored start:
  - Stimulus: start with len=0.
  - Required: out_valid in the next cycle with out_sum=0 and out_count=0.
  - Also: a start pulse during ACCUM leaves len_latched and cnt unchanged.
- Backpressure and stalls:
  - Stimulus: len=4 with in_valid toggling randomly; out_ready held low for 5 cycles in DONE.
  - Required: the sum equals the reference total; out_* values are stable while out_valid=1 and out_ready=0; IDLE is reached one cycle after the handshake.
